// File: rtl/mul8u_pipe_if.sv
// Operand/product bus for the pipelined 8x8 unsigned multiplier.
// The master supplies operand pairs and the slave returns registered products.
interface mul8u_pipe_if;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  logic              in_valid;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic [PROD_W-1:0] y;

  modport master (output in_valid, a, b, input  out_valid, y);
  modport slave  (input  in_valid, a, b, output out_valid, y);
endinterface

// File: rtl/mul8u_pipe.sv
// Two-stage pipelined 8x8 unsigned multiplier.
// Nibble partial products are formed in stage 1 and summed in stage 2, giving a fixed two-cycle latency.
module mul8u_pipe (
  input  logic         clk,
  input  logic         rst_n,
  mul8u_pipe_if.slave  bus
);
  localparam int unsigned OP_W   = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned PP_W   = OP_W + NIB_W;
  localparam int unsigned PROD_W = 2 * OP_W;

  logic [PP_W-1:0]   lo_q;
  logic [PP_W-1:0]   hi_q;
  logic              s1_valid_q;
  logic [PROD_W-1:0] y_q;
  logic              out_valid_q;

  // Stage 1: partial products a*b[3:0] and a*b[7:4]; the data registers hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q       <= '0;
      hi_q       <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        lo_q <= PP_W'(bus.a) * PP_W'(bus.b[NIB_W-1:0]);
        hi_q <= PP_W'(bus.a) * PP_W'(bus.b[OP_W-1:NIB_W]);
      end
    end
  end

  // Stage 2: recombine the partial products; y keeps its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        y_q <= PROD_W'(lo_q) + (PROD_W'(hi_q) << NIB_W);
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mul8u_pipe.sv
// Scoreboard bench for mul8u_pipe.
// Each sampled edge enqueues the expected result, and the entry is retired two edges later.
module tb_mul8u_pipe;
  typedef struct packed {
    logic        v;
    logic [15:0] y;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t exp_q[$];
  logic [15:0] last_y = 16'd0;

  mul8u_pipe_if bus();

  mul8u_pipe u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Record what each sampled edge should produce two edges later.
  always @(posedge clk) begin
    if (rst_n) begin
      exp_t e;
      e.v = bus.in_valid;
      e.y = 16'(32'(bus.a) * 32'(bus.b));
      exp_q.push_back(e);
    end
  end

  // Retire the entry whose result is due now; nothing may be valid before two edges have passed.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() >= 2) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_valid", 32'(bus.out_valid), 32'(e.v));
        if (e.v) begin
          check("y", 32'(bus.y), 32'(e.y));
          last_y = e.y;
        end else begin
          check("y_hold", 32'(bus.y), 32'(last_y));
        end
      end else begin
        check("early_valid", 32'(bus.out_valid), 32'd0);
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
  endtask

  // Assert reset between edges, confirm the outputs clear at once and stay clear, then release.
  task automatic reset_pulse(input int hold_cycles);
    #2 rst_n = 1'b0;
    #1;
    check("rst_y_now", 32'(bus.y), 32'd0);
    check("rst_ov_now", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    last_y = 16'd0;
    bus.in_valid = 1'b1;
    bus.a        = 8'd255;
    bus.b        = 8'd255;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check("rst_y_hold", 32'(bus.y), 32'd0);
      check("rst_ov_hold", 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd99, 8'd99);
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.a        = 8'd255;
    bus.b        = 8'd255;
    #3;
    reset_pulse(3);
    idle(2);

    // Corner operands, streamed back-to-back
    step(1'b1, 8'd0,   8'd0);
    step(1'b1, 8'd0,   8'd255);
    step(1'b1, 8'd255, 8'd0);
    step(1'b1, 8'd255, 8'd255);
    idle(3);

    // Typical values
    step(1'b1, 8'd13,  8'd7);
    step(1'b1, 8'd128, 8'd2);
    step(1'b1, 8'd200, 8'd100);
    idle(3);

    // A bubble in the middle of the stream
    step(1'b1, 8'd13,  8'd7);
    step(1'b0, 8'd99,  8'd99);
    step(1'b1, 8'd200, 8'd100);
    idle(3);

    // Reset while two products are still in flight
    step(1'b1, 8'd255, 8'd255);
    step(1'b1, 8'd128, 8'd2);
    reset_pulse(2);
    step(1'b1, 8'd13, 8'd7);
    idle(4);

    // Every operand pair
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] ab;
      ab = 16'(i);
      step(1'b1, ab[15:8], ab[7:0]);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/mul8u_pipe.md
Name: mul8u_pipe

Overview:
- Clocked 8x8 unsigned integer multiplier with a registered 16-bit product.
- It is the synchronous form of the team's behavioural 8-bit unsigned multiplier and is meant for datapaths needing a fixed-latency, fully pipelined product.
- Two pipeline stages; accepts one operand pair per cycle; valid flag travels alongside the data.

Parameters:
- none. Widths are fixed: operands 8 bits, product 16 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  operand pair on a/b is valid this cycle
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- out_valid  output  1  y holds a new product this cycle
- y  output  16  product a*b, unsigned

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0, and immediately on its assertion:
  - y=0, out_valid=0
  - all pipeline registers and stage valid bits are cleared
- Arithmetic:
  - y = a*b, unsigned, full 16-bit result; no truncation or overflow is possible.
  - Maximum result is 255*255 = 65025 (0xFE01).
  - No signed interpretation of any bit.
- Stage 1 (edge N, when in_valid=1):
  - Form partial products lo = a*b[3:0] (12 bits) and hi = a*b[7:4] (12 bits).
  - Register lo and hi; set s1_valid=1.
  - If in_valid=0, s1_valid=0 and the stage-1 data registers hold their values.
- Stage 2 (edge N+1, when s1_valid=1):
  - y <= lo + (hi << 4); out_valid <= 1.
  - If s1_valid=0, out_valid <= 0 and y holds its last value.
- Latency and throughput:
  - Exactly 2 clk edges from sampling an in_valid=1 pair to y/out_valid presenting its product.
  - One result per cycle when inputs stream back-to-back; results emerge in input order.
- No backpressure: the consumer must accept y in the cycle out_valid=1.
- Bubbles (in_valid=0) propagate as out_valid=0 two cycles later; y is not cleared on bubbles.
- a/b are ignored when in_valid=0.
- Reset mid-operation: in-flight products are discarded, and no out_valid pulse appears for them after reset release.
- The first valid input after rst_n rises produces out_valid two edges later.
- Outputs are driven only from registers; there is no combinational path from a/b to y.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=255, b=255 -> y=0, out_valid=0 throughout. Assert rst_n asynchronously between edges -> outputs clear immediately.
- Corner streaming: apply (0,0), (0,255), (255,0), (255,255) on consecutive cycles with in_valid=1 -> starting 2 edges later, y = 0, 0, 0, 65025 on consecutive cycles, out_valid=1 each.
- Typical values: apply (13,7), (128,2), (200,100) back-to-back -> y = 91, 256, 20000, in order, with 2-cycle latency.
- Bubbles: apply (13,7), then in_valid=0 with a=99, b=99, then (200,100) -> out_valid pattern 1,0,1; y=91, holds 91, then 20000.
- Reset mid-flight: apply (255,255) and (128,2), then pulse rst_n low before they emerge -> no out_valid pulse afterwards; the next input (13,7) yields 91 exactly 2 edges after sampling.
- Exhaustive: all 65536 (a,b) pairs streamed -> each y equals the a*b reference, 2-cycle aligned, out_valid=1 for every result.
